// File: rtl/seg_disp_mngr_n_pkg.sv
// seg_disp_pkg: shared event codes, segment constants, display state and hex glyph table.
package seg_disp_pkg;

    localparam logic [3:0] EV_APPLE  = 4'hA;
    localparam logic [3:0] EV_BANANA = 4'hB;
    localparam logic [3:0] EV_CARROT = 4'hC;
    localparam logic [3:0] EV_DATE   = 4'hD;
    localparam logic [3:0] EV_ERROR  = 4'hE;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    typedef enum logic {SHOW_CREDIT, SHOW_EVT} disp_state_t;

    // Segment order {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h7E;
            4'h1: hex_glyph = 7'h30;
            4'h2: hex_glyph = 7'h6D;
            4'h3: hex_glyph = 7'h79;
            4'h4: hex_glyph = 7'h33;
            4'h5: hex_glyph = 7'h5B;
            4'h6: hex_glyph = 7'h5F;
            4'h7: hex_glyph = 7'h70;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h7B;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h1F;
            4'hC: hex_glyph = 7'h4E;
            4'hD: hex_glyph = 7'h3D;
            4'hE: hex_glyph = 7'h4F;
            default: hex_glyph = 7'h47;
        endcase
    endfunction

endpackage

// File: rtl/seg_disp_mngr_n_seg7_hex_decoder.sv
// seg7_hex_decoder: combinational 4-bit value to seven-segment glyph.
module seg7_hex_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb glyph = hex_glyph(value);

endmodule

// File: rtl/seg_disp_mngr_n.sv
// seg_disp_mngr_n: multi-digit credit/event display manager with pending-event buffer.
// Optional SEG_DISP_BLINK_EN makes an error code blink during its hold.
module seg_disp_mngr_n
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int HOLD_CYCLES = 6,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ev_valid,
    input  logic [3:0]              ev_code,
    output logic                    ev_ready,
    input  logic [4*NUM_DIGITS-1:0] credit,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    disp_state_t             state, state_n;
    logic [HW-1:0]           hold_cnt, hold_n;
    logic [3:0]              cur_code, cur_n, pend_code, pend_code_n;
    logic                    pend_valid, pend_valid_n;
    logic                    acc, load, evt_n, blink_off;
    logic [7*NUM_DIGITS-1:0] seg_n;

    assign ev_ready = !pend_valid;
    assign acc      = ev_valid && ev_ready;

    always_comb begin
        state_n      = state;
        hold_n       = hold_cnt;
        cur_n        = cur_code;
        pend_code_n  = pend_code;
        pend_valid_n = pend_valid;
        load         = 1'b0;
        if (state == SHOW_CREDIT) begin
            if (acc) begin
                state_n = SHOW_EVT;
                cur_n   = ev_code;
                load    = 1'b1;
            end
        end else if (hold_cnt == HW'(1)) begin
            if (pend_valid) begin
                cur_n        = pend_code;
                pend_valid_n = 1'b0;
                load         = 1'b1;
            end else if (acc) begin
                cur_n = ev_code;
                load  = 1'b1;
            end else begin
                state_n = SHOW_CREDIT;
                hold_n  = '0;
            end
        end else begin
            hold_n = hold_cnt - HW'(1);
            if (acc && ev_code == EV_ERROR) begin
                cur_n = EV_ERROR;
                load  = 1'b1;
            end else if (acc) begin
                pend_code_n  = ev_code;
                pend_valid_n = 1'b1;
            end
        end
        if (load) hold_n = HW'(HOLD_CYCLES);
    end

    assign evt_n = (state_n == SHOW_EVT);

`ifdef SEG_DISP_BLINK_EN
    logic phase, phase_n;
    // Phase 0 shows the glyph, so every fresh hold starts visible
    assign phase_n   = load ? 1'b0 : !phase;
    assign blink_off = evt_n && cur_n == EV_ERROR && phase_n;
    always_ff @(posedge clk) begin
        if (!reset) phase <= 1'b0;
        else        phase <= phase_n;
    end
`else
    assign blink_off = 1'b0;
`endif

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] nib, val;
        logic [6:0] glyph;
        logic       lz;
        assign nib = credit[4*i +: 4];
        assign val = evt_n ? cur_n : nib;
        // Blank when this digit and every higher one are zero
        assign lz  = (i != 0) && (LZ_BLANK != 0) && ~|credit[4*NUM_DIGITS-1:4*i];
        seg7_hex_decoder u_dec (.value(val), .glyph(glyph));
        assign seg_n[7*i +: 7] = evt_n ? (blink_off ? SEG_BLANK : glyph) :
                                 (nib > 4'd9) ? SEG_DASH :
                                 lz ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SHOW_CREDIT;
            hold_cnt   <= '0;
            cur_code   <= '0;
            pend_code  <= '0;
            pend_valid <= 1'b0;
            seg        <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            cur_code   <= cur_n;
            pend_code  <= pend_code_n;
            pend_valid <= pend_valid_n;
            seg        <= seg_n;
            busy       <= evt_n;
        end
    end

endmodule
